// File: rtl/key_matrix_scan.sv
// key_matrix_scan: 4x4 active-low keypad scanner with debounce and an 8-digit BCD entry register.
// Columns are driven one-hot low. Each column dwells for 2^SCAN_W cycles, and the rows are
// sampled at the end of that dwell. A frame covers four columns and produces at most one code:
// the first hit in scan order. Frame results are debounced by a small FSM, and each accepted
// press shifts a decimal digit into bcd8d.
// Optional build macro: KEY_AUTOREPEAT_EN enables auto-repeat of a held key every
// REPEAT_FRAMES frames. When the macro is undefined, each press produces exactly one key_valid.

module key_matrix_scan #(
    parameter int unsigned SCAN_W        = 16,
    parameter int unsigned DEB_FRAMES    = 3,
    parameter int unsigned REPEAT_FRAMES = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic [3:0]  key_row,
    output logic [3:0]  key_col,
    output logic [3:0]  key_code,
    output logic        key_valid,
    output logic        key_held,
    output logic [31:0] bcd8d
);

    // Reject illegal configurations at elaboration time.
    if (SCAN_W < 2) begin : g_bad_scan_w
        $error("SCAN_W must be at least 2");
    end
    if (DEB_FRAMES < 2 || DEB_FRAMES > 15) begin : g_bad_deb_frames
        $error("DEB_FRAMES must be in 2..15");
    end
    if (REPEAT_FRAMES < 1) begin : g_bad_repeat_frames
        $error("REPEAT_FRAMES must be at least 1");
    end

    localparam logic [3:0] DebLast = 4'(DEB_FRAMES);

    typedef enum logic [1:0] {
        StIdle,
        StDeb,
        StPressed,
        StRel
    } state_e;

    // Row synchronizer.
    logic [3:0] row_meta_q;
    logic [3:0] row_sync_q;

    // Column scan timing.
    logic [SCAN_W-1:0] div_q;
    logic              tick;
    logic              frame_end;
    logic [1:0]        col_idx_q;
    logic [1:0]        col_idx_d;
    logic [3:0]        key_col_q;
    logic [3:0]        key_col_d;

    // Per-column hit and frame accumulator.
    logic       col_hit;
    logic [1:0] hit_row;
    logic       acc_found_q;
    logic       acc_found_d;
    logic [3:0] acc_code_q;
    logic [3:0] acc_code_d;
    logic       frame_found;
    logic [3:0] frame_code;

    // Debounce FSM and outputs.
    state_e     state_q;
    state_e     state_d;
    logic [3:0] cand_q;
    logic [3:0] cand_d;
    logic [3:0] cnt_q;
    logic [3:0] cnt_d;
    logic [3:0] key_code_q;
    logic [3:0] key_code_d;
    logic       key_held_q;
    logic       key_held_d;
    logic       key_valid_q;
    logic       accept;
    logic [3:0] accept_code;
    logic [31:0] bcd_q;
    logic [31:0] bcd_d;

`ifdef KEY_AUTOREPEAT_EN
    localparam int unsigned    RepW    = $clog2(REPEAT_FRAMES + 1);
    localparam logic [RepW-1:0] RepLast = RepW'(REPEAT_FRAMES);
    logic [RepW-1:0] rep_q;
    logic [RepW-1:0] rep_d;
`endif

    assign tick      = &div_q;
    assign frame_end = tick && (col_idx_q == 2'd3);

    // Two-flop synchronizer on the asynchronous row inputs; idle rows read high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_meta_q <= 4'hF;
            row_sync_q <= 4'hF;
        end else begin
            row_meta_q <= key_row;
            row_sync_q <= row_meta_q;
        end
    end

    // Free-running dwell divider; the all-ones value marks the end of a column.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q <= '0;
        end else begin
            div_q <= div_q + 1'b1;
        end
    end

    // Next column index and its registered one-hot-low drive pattern.
    always_comb begin
        col_idx_d = col_idx_q;
        key_col_d = key_col_q;
        if (tick) begin
            col_idx_d = col_idx_q + 2'd1;
            key_col_d = ~(4'b0001 << col_idx_d);
        end
    end

    // Column index and column drive registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_idx_q <= 2'd0;
            key_col_q <= 4'b1110;
        end else begin
            col_idx_q <= col_idx_d;
            key_col_q <= key_col_d;
        end
    end

    // Lowest active row within the current column.
    always_comb begin
        col_hit = ~&row_sync_q;
        hit_row = 2'd0;
        if (!row_sync_q[0]) begin
            hit_row = 2'd0;
        end else if (!row_sync_q[1]) begin
            hit_row = 2'd1;
        end else if (!row_sync_q[2]) begin
            hit_row = 2'd2;
        end else if (!row_sync_q[3]) begin
            hit_row = 2'd3;
        end
    end

    // Frame result including the column being sampled now; earlier columns take priority.
    always_comb begin
        frame_found = acc_found_q | col_hit;
        frame_code  = acc_found_q ? acc_code_q : {hit_row, col_idx_q};
        acc_found_d = acc_found_q;
        acc_code_d  = acc_code_q;
        if (tick) begin
            if (frame_end) begin
                acc_found_d = 1'b0;
                acc_code_d  = 4'd0;
            end else if (!acc_found_q && col_hit) begin
                acc_found_d = 1'b1;
                acc_code_d  = {hit_row, col_idx_q};
            end
        end
    end

    // Frame accumulator registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_found_q <= 1'b0;
            acc_code_q  <= 4'd0;
        end else begin
            acc_found_q <= acc_found_d;
            acc_code_q  <= acc_code_d;
        end
    end

    // Debounce FSM next state; it advances only on frame-end ticks.
    always_comb begin
        state_d     = state_q;
        cand_d      = cand_q;
        cnt_d       = cnt_q;
        key_code_d  = key_code_q;
        key_held_d  = key_held_q;
        accept      = 1'b0;
        accept_code = key_code_q;
`ifdef KEY_AUTOREPEAT_EN
        rep_d       = rep_q;
`endif
        if (frame_end) begin
            case (state_q)
                StIdle: begin
                    if (frame_found) begin
                        state_d = StDeb;
                        cand_d  = frame_code;
                        cnt_d   = 4'd1;
                    end
                end
                StDeb: begin
                    if (!frame_found) begin
                        state_d = StIdle;
                        cnt_d   = 4'd0;
                    end else if (frame_code != cand_q) begin
                        // A different key restarts the count rather than aborting.
                        cand_d = frame_code;
                        cnt_d  = 4'd1;
                    end else if (cnt_q + 4'd1 == DebLast) begin
                        state_d     = StPressed;
                        cnt_d       = 4'd0;
                        key_code_d  = cand_q;
                        key_held_d  = 1'b1;
                        accept      = 1'b1;
                        accept_code = cand_q;
`ifdef KEY_AUTOREPEAT_EN
                        rep_d       = '0;
`endif
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
                StPressed: begin
                    if (!frame_found) begin
                        state_d = StRel;
                        cnt_d   = 4'd1;
`ifdef KEY_AUTOREPEAT_EN
                        rep_d   = '0;
`endif
                    end else begin
`ifdef KEY_AUTOREPEAT_EN
                        if (frame_code == key_code_q) begin
                            if (rep_q + RepW'(1) == RepLast) begin
                                accept      = 1'b1;
                                accept_code = key_code_q;
                                rep_d       = '0;
                            end else begin
                                rep_d = rep_q + RepW'(1);
                            end
                        end else begin
                            rep_d = '0;
                        end
`endif
                    end
                end
                StRel: begin
                    if (frame_found) begin
                        state_d = StPressed;
                        cnt_d   = 4'd0;
                    end else if (cnt_q + 4'd1 == DebLast) begin
                        state_d    = StIdle;
                        cnt_d      = 4'd0;
                        key_held_d = 1'b0;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
                default: begin
                    state_d = StIdle;
                    cnt_d   = 4'd0;
                end
            endcase
        end
    end

    // Digit register update: shift in 0..9, clear on 0xA, ignore others; clr always wins.
    always_comb begin
        bcd_d = bcd_q;
        if (accept) begin
            if (accept_code <= 4'd9) begin
                bcd_d = {bcd_q[27:0], accept_code};
            end else if (accept_code == 4'hA) begin
                bcd_d = 32'd0;
            end
        end
        if (clr) begin
            bcd_d = 32'd0;
        end
    end

    // FSM, output, and digit registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            cand_q      <= 4'd0;
            cnt_q       <= 4'd0;
            key_code_q  <= 4'd0;
            key_held_q  <= 1'b0;
            key_valid_q <= 1'b0;
            bcd_q       <= 32'd0;
        end else begin
            state_q     <= state_d;
            cand_q      <= cand_d;
            cnt_q       <= cnt_d;
            key_code_q  <= key_code_d;
            key_held_q  <= key_held_d;
            key_valid_q <= accept;
            bcd_q       <= bcd_d;
        end
    end

`ifdef KEY_AUTOREPEAT_EN
    // Auto-repeat frame counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rep_q <= '0;
        end else begin
            rep_q <= rep_d;
        end
    end
`endif

    assign key_col   = key_col_q;
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_held  = key_held_q;
    assign bcd8d     = bcd_q;

endmodule

// File: tb/tb_key_matrix_scan.sv
// Bench for key_matrix_scan (SCAN_W=2, DEB_FRAMES=3: 4-cycle columns, 16-cycle frames).
// A keypad model drives the rows from the column outputs. A frame-level reference model
// works from the history of frame results.

module tb_key_matrix_scan;

    localparam int DEB = 3;
    localparam int FRAME = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clr = 1'b0;
    logic [3:0]  key_row;
    logic [3:0]  key_col;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;
    logic [31:0] bcd8d;

    logic [15:0] keys_down = 16'h0;

    int checks = 0;
    int errors = 0;
    int k = 0;
    int valid_seen = 0;

    // Reference model state.
    int          hist[$];
    bit          m_held = 1'b0;
    bit          m_pulse = 1'b0;
    logic [3:0]  m_code = 4'd0;
    logic [31:0] m_bcd = 32'd0;

    key_matrix_scan #(
        .SCAN_W       (2),
        .DEB_FRAMES   (3),
        .REPEAT_FRAMES(32)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .key_row  (key_row),
        .key_col  (key_col),
        .key_code (key_code),
        .key_valid(key_valid),
        .key_held (key_held),
        .bcd8d    (bcd8d)
    );

    always #5 clk = ~clk;

    // Keypad: a pressed key shorts its row to its column when that column is driven low.
    always_comb begin
        key_row = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keys_down[r*4+c] && !key_col[c]) key_row[r] = 1'b0;
            end
        end
    end

    function automatic logic [15:0] kmask(input int code);
        return 16'(1) << code;
    endfunction

    // First pressed key in scan order: column-major, lowest row first; -1 if none.
    function automatic int first_hit(input logic [15:0] keys);
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                if (keys[r*4+c]) return r * 4 + c;
            end
        end
        return -1;
    endfunction

    function automatic bit last_all(input int val);
        if (hist.size() < DEB) return 1'b0;
        for (int i = 0; i < DEB; i++) begin
            if (hist[hist.size()-1-i] != val) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Model update for one completed frame.
    task automatic model_frame();
        int res;
        res = first_hit(keys_down);
        hist.push_back(res);
        if (hist.size() > DEB) void'(hist.pop_front());
        m_pulse = 1'b0;
        if (!m_held && res >= 0 && last_all(res)) begin
            m_held  = 1'b1;
            m_pulse = 1'b1;
            m_code  = 4'(res);
            if (res <= 9) m_bcd = {m_bcd[27:0], 4'(res)};
            else if (res == 10) m_bcd = 32'd0;
        end else if (m_held && last_all(-1)) begin
            m_held = 1'b0;
        end
    endtask

    // One clock: advance, update model, compare every output.
    task automatic step_cycle();
        bit clr_s;
        logic [3:0] exp_col;
        clr_s = clr;
        @(posedge clk);
        #1;
        clr = 1'b0;
        k++;
        if (k == FRAME) begin
            model_frame();
            k = 0;
        end else begin
            m_pulse = (k == 0) ? m_pulse : 1'b0;
        end
        if (clr_s) m_bcd = 32'd0;
        exp_col = ~(4'b0001 << (k / 4));
        if (key_valid === 1'b1) valid_seen++;
        check("key_col", {28'd0, key_col}, {28'd0, exp_col});
        check("key_valid", {31'd0, key_valid}, {31'd0, (k == 0) && m_pulse});
        check("key_code", {28'd0, key_code}, {28'd0, m_code});
        check("key_held", {31'd0, key_held}, {31'd0, m_held});
        check("bcd8d", bcd8d, m_bcd);
    endtask

    task automatic run_frame(input logic [15:0] keys, input bit clr_end);
        keys_down = keys;
        for (int i = 0; i < FRAME; i++) begin
            if (i == FRAME - 1) clr = clr_end;
            step_cycle();
        end
    endtask

    // Enter with time just after a rising edge; leaves rst deasserted mid-cycle.
    task automatic do_reset(input int hold);
        rst = 1'b1;
        #1;
        hist.delete();
        m_held = 1'b0; m_pulse = 1'b0; m_code = 4'd0; m_bcd = 32'd0; k = 0;
        check("rst_col", {28'd0, key_col}, 32'hE);
        check("rst_code", {28'd0, key_code}, 32'h0);
        check("rst_valid", {31'd0, key_valid}, 32'h0);
        check("rst_held", {31'd0, key_held}, 32'h0);
        check("rst_bcd", bcd8d, 32'h0);
        repeat (hold) @(posedge clk);
        #1;
        check("rst_hold_col", {28'd0, key_col}, 32'hE);
        check("rst_hold_bcd", bcd8d, 32'h0);
        rst = 1'b0;
    endtask

    task automatic press_key(input int code);
        for (int i = 0; i < DEB; i++) run_frame(kmask(code), 1'b0);
        for (int i = 0; i < DEB; i++) run_frame(16'h0, 1'b0);
    endtask

    initial begin
        int v0;
        int code;
        int dur;
        int gap;
        logic [15:0] ks;

        @(posedge clk);
        #1;
        do_reset(3);
        run_frame(16'h0, 1'b0);
        run_frame(16'h0, 1'b0);

        // Bounce: 2 frames pressed, 1 released, four times.
        v0 = valid_seen;
        repeat (4) begin
            run_frame(kmask(5), 1'b0);
            run_frame(kmask(5), 1'b0);
            run_frame(16'h0, 1'b0);
        end
        check("bounce_valid_count", valid_seen - v0, 0);
        check("bounce_bcd", bcd8d, 32'h0);

        // Clean press of code 5 for five frames, then release.
        v0 = valid_seen;
        run_frame(kmask(5), 1'b0);
        run_frame(kmask(5), 1'b0);
        check("press_no_early_valid", valid_seen - v0, 0);
        run_frame(kmask(5), 1'b0);
        check("press_valid", {31'd0, key_valid}, 32'h1);
        check("press_code", {28'd0, key_code}, 32'h5);
        check("press_bcd", bcd8d, 32'h00000005);
        run_frame(kmask(5), 1'b0);
        run_frame(kmask(5), 1'b0);
        run_frame(16'h0, 1'b0);
        run_frame(16'h0, 1'b0);
        check("release_still_held", {31'd0, key_held}, 32'h1);
        run_frame(16'h0, 1'b0);
        check("release_done", {31'd0, key_held}, 32'h0);
        check("press_single_valid", valid_seen - v0, 1);

        // Digit sequence 1..9, then 0xA clears.
        for (int d = 1; d <= 9; d++) press_key(d);
        check("digits_bcd", bcd8d, 32'h23456789);
        press_key(10);
        check("clear_key_bcd", bcd8d, 32'h0);

        // Two keys at once: code 9 (column 1) wins over code 6 (column 2).
        run_frame(kmask(6) | kmask(9), 1'b0);
        run_frame(kmask(6) | kmask(9), 1'b0);
        run_frame(kmask(6) | kmask(9), 1'b0);
        check("multi_code", {28'd0, key_code}, 32'h9);
        check("multi_bcd", bcd8d, 32'h9);
        for (int i = 0; i < DEB; i++) run_frame(16'h0, 1'b0);

        // clr sampled on the same edge as the accepting update.
        run_frame(kmask(3), 1'b0);
        run_frame(kmask(3), 1'b0);
        run_frame(kmask(3), 1'b1);
        check("clr_valid", {31'd0, key_valid}, 32'h1);
        check("clr_code", {28'd0, key_code}, 32'h3);
        check("clr_bcd", bcd8d, 32'h0);
        for (int i = 0; i < DEB; i++) run_frame(16'h0, 1'b0);

        // Reset in the middle of debounce frame 2.
        run_frame(kmask(5), 1'b0);
        for (int i = 0; i < 8; i++) step_cycle();
        do_reset(2);
        v0 = valid_seen;
        run_frame(kmask(5), 1'b0);
        run_frame(kmask(5), 1'b0);
        check("rst_deb_no_valid", valid_seen - v0, 0);
        check("rst_deb_not_held", {31'd0, key_held}, 32'h0);
        run_frame(kmask(5), 1'b0);
        check("rst_deb_valid", {31'd0, key_valid}, 32'h1);
        check("rst_deb_bcd", bcd8d, 32'h5);
        for (int i = 0; i < DEB; i++) run_frame(16'h0, 1'b0);

        // Randomized presses with glitches, chords, and occasional clr.
        for (int n = 0; n < 40; n++) begin
            code = int'($urandom_range(0, 15));
            ks = kmask(code);
            if ($urandom_range(0, 4) == 0) ks = ks | kmask(int'($urandom_range(0, 15)));
            dur = int'($urandom_range(1, 6));
            gap = int'($urandom_range(1, 5));
            for (int j = 0; j < dur; j++) begin
                run_frame(($urandom_range(0, 5) == 0) ? 16'h0 : ks, $urandom_range(0, 15) == 0);
            end
            for (int j = 0; j < gap; j++) run_frame(16'h0, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/key_matrix_scan.md
Name: key_matrix_scan

Overview:
- Input-side counterpart of the 8-digit 7-segment display driver.
- Scans a 4x4 active-low key matrix, debounces the result and encodes one key code per press.
- Shifts numeric keys into a 32-bit, 8-digit BCD register that feeds the display driver's bcd8d input.
- Sits between the keypad pins and the display controller.

Parameters:
SCAN_W, 16, column dwell is 2^SCAN_W clk cycles; legal minimum is 2.
DEB_FRAMES, 3, consecutive identical scan frames needed to accept a press or a release; legal range 2..15.
REPEAT_FRAMES, 32, auto-repeat period in frames; used only with KEY_AUTOREPEAT_EN.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
clr  in  1  synchronous clear of bcd8d, level
key_row  in  4  matrix row inputs, active-low, pulled up
key_col  out  4  column drive, one-hot active-low
key_code  out  4  last accepted key code = row*4 + col
key_valid  out  1  one-cycle pulse per accepted press
key_held  out  1  high while an accepted key remains pressed
bcd8d  out  32  digit register; newest digit in [3:0]

Behaviour:
- Reset values: key_col=4'b1110, key_code=0, key_valid=0, key_held=0, bcd8d=0. Internally: divider=0, col_idx=0, FSM=IDLE, synchronizer=4'hF.
- key_row passes through a 2-FF synchronizer.
- Divider: free-running SCAN_W-bit counter. tick = divider all-ones; the counter wraps.
- Scanning on tick:
  - Sample the synchronized rows for the current col_idx, then advance col_idx. key_col = ~(1<<col_idx) is registered.
  - Sampling at the end of the dwell gives at least 2 cycles of settling margin after the column changes.
- Frame: the 4 ticks for col 0..3.
  - The frame result is the first hit in scan order: lowest column first, then lowest row within that column.
  - Result = found flag + code.
  - The result is evaluated on the col-3 tick, and the frame accumulator clears.
- FSM, updated once per frame end:
  - IDLE: found -> DEB, with cand=code and cnt=1.
  - DEB: found and code==cand -> cnt+1; when cnt reaches DEB_FRAMES -> PRESSED.
  - DEB: found with a different code -> stay in DEB, cand=new code, cnt=1.
  - DEB: not found -> IDLE.
  - Entering PRESSED: key_code=cand, key_held=1, key_valid pulses for exactly the cycle after the frame-end tick.
  - PRESSED: not found -> REL with cnt=1. Found with any code -> stay; no new pulse, because a new key requires a release first.
  - REL: not found -> cnt+1; when cnt reaches DEB_FRAMES -> IDLE and key_held=0.
  - REL: found -> PRESSED with cnt=0.
- bcd8d update, on the same edge that sets key_valid:
  - code 0..9: bcd8d <= {bcd8d[27:0], code}; the oldest digit is dropped.
  - code 0xA: bcd8d <= 0.
  - codes 0xB..0xF: bcd8d unchanged.
  - clr=1 forces bcd8d to 0 and wins over a same-cycle key update. key_valid still pulses and key_code still updates.
- Reset mid-operation: rst asserted at any time returns every output and all state to reset values immediately. Scanning restarts at col 0 after rst deasserts.
- Latency: a clean press is reported DEB_FRAMES frames after its first sampled frame, plus 1 cycle.

Optional Feature:
KEY_AUTOREPEAT_EN:
- Defined: in PRESSED, a repeat counter increments each frame that reports the same code as key_code.
  - On reaching REPEAT_FRAMES, key_valid pulses again with the same code and bcd8d applies the same update rule. The counter then restarts.
  - A different code or a miss clears the counter.
- Undefined: exactly one key_valid per press. The repeat counter logic is not synthesized.

Test Plan:
All tests use SCAN_W=2, DEB_FRAMES=3 (column = 4 cycles, frame = 16 cycles).
- Reset: hold rst, then release -> all outputs at reset values; key_col steps 1110,1101,1011,0111,1110 every 4 cycles.
- Clean press: pull key_row[1] low while key_col[1]=0 (code 5) for 5 frames, then release -> one key_valid pulse in frame 3 with key_code=5, bcd8d=32'h00000005. key_held stays high until 3 empty frames have passed.
- Bounce: pattern of 2 frames pressed and 1 frame released, repeated 4 times -> key_valid never asserts; bcd8d stays 0.
- Digit sequence: keys 1..9 entered individually with releases between -> bcd8d=32'h23456789. Then key 0xA -> bcd8d=0.
- Multi-key and priority: codes 6 and 9 pressed together -> key_code=9, because col 1 is scanned before col 2. Asserting clr in the key_valid cycle of a code-3 press -> bcd8d=0 and key_code=3.
- Reset mid-debounce: rst pulsed during DEB frame 2 -> no key_valid; after rst releases, the press needs 3 full new frames before it is accepted.
